// File: rtl/floo_mcast_fork.sv
// Multicast fork: replicates one flit to every output selected by select_i and
// releases the input once all selected outputs have accepted. Optional input cut: FLOO_MCAST_FORK_CUT_EN.
module floo_mcast_fork #(
   parameter int unsigned NumOutputs = 5,
   parameter type         flit_t     = logic,
   parameter int unsigned CntWidth   = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  flit_t                        data_i,
   input  logic [NumOutputs-1:0]        select_i,
   input  logic [$clog2(NumOutputs):0]  rep_coeff_i,
   output logic [NumOutputs-1:0]        valid_o,
   input  logic [NumOutputs-1:0]        ready_i,
   output flit_t                        data_o,
   output logic                         busy_o,
   output logic                         empty_sel_o,
   output logic [CntWidth-1:0]          fork_cnt_o
);

   localparam int unsigned CoeffWidth = $clog2(NumOutputs) + 1;

   logic                  forkValid;
   logic                  forkReady;
   flit_t                 forkData;
   logic [NumOutputs-1:0] forkSelect;

   logic [NumOutputs-1:0] done_q, done_d;
   logic [NumOutputs-1:0] hs;
   logic                  allDone;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic                  emptySel_q, emptySel_d;

`ifdef FLOO_MCAST_FORK_CUT_EN
   // Two-entry buffer: ready_o only reflects occupancy, so it never sees ready_i.
   flit_t                 dataMem_q  [2];
   logic [NumOutputs-1:0] selMem_q   [2];
   logic [CoeffWidth-1:0] coeffMem_q [2];
   logic                  wrPtr_q, rdPtr_q;
   logic [1:0]            count_q;
   logic                  push, pop;
   logic [CoeffWidth-1:0] forkCoeff;

   assign ready_o    = ~rst_i & (count_q != 2'd2);
   assign push       = valid_i & ready_o;
   assign pop        = forkReady;
   assign forkValid  = ~rst_i & (count_q != 2'd0);
   assign forkData   = dataMem_q[rdPtr_q];
   assign forkSelect = selMem_q[rdPtr_q];
   assign forkCoeff  = coeffMem_q[rdPtr_q];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrPtr_q <= 1'b0;
         rdPtr_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (push) wrPtr_q <= ~wrPtr_q;
         if (pop)  rdPtr_q <= ~rdPtr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         dataMem_q[wrPtr_q]  <= data_i;
         selMem_q[wrPtr_q]   <= select_i;
         coeffMem_q[wrPtr_q] <= rep_coeff_i;
      end
   end
`else
   assign forkValid  = valid_i & ~rst_i;
   assign forkData   = data_i;
   assign forkSelect = select_i;
   assign ready_o    = forkReady;
`endif

   // Ports that already took the flit are masked so they are never re-offered.
   assign valid_o   = {NumOutputs{forkValid}} & forkSelect & ~done_q;
   assign hs        = valid_o & ready_i;
   assign allDone   = ((done_q | hs) & forkSelect) == forkSelect;
   assign forkReady = forkValid & allDone;
   assign data_o    = forkData;
   assign busy_o    = |done_q;
   assign empty_sel_o = emptySel_q;
   assign fork_cnt_o  = cnt_q;

   always_comb begin
      done_d     = done_q | hs;
      cnt_d      = cnt_q;
      emptySel_d = 1'b0;
      if (forkReady) begin
         done_d = '0;
         if (forkSelect == '0) emptySel_d = 1'b1;
         else                  cnt_d      = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         done_q     <= '0;
         cnt_q      <= '0;
         emptySel_q <= 1'b0;
      end else begin
         done_q     <= done_d;
         cnt_q      <= cnt_d;
         emptySel_q <= emptySel_d;
      end
   end

`ifndef SYNTHESIS
   assert property (@(posedge clk_i) disable iff (rst_i)
      (valid_i && !ready_o) |=> (valid_i && $stable(data_i) && $stable(select_i) && $stable(rep_coeff_i)))
      else $error("floo_mcast_fork: input changed or dropped before acceptance");

   assert property (@(posedge clk_i) disable iff (rst_i)
      valid_i |-> ($countones(select_i) == int'(rep_coeff_i)))
      else $error("floo_mcast_fork: rep_coeff_i does not match popcount of select_i");

`ifdef FLOO_MCAST_FORK_CUT_EN
   assert property (@(posedge clk_i) disable iff (rst_i)
      forkValid |-> ($countones(forkSelect) == int'(forkCoeff)))
      else $error("floo_mcast_fork: buffered rep_coeff does not match buffered select");
`endif
`endif

endmodule

// File: tb/tb_floo_mcast_fork.sv
// Self-checking bench for floo_mcast_fork; per-port scoreboard queues hold the
// flits each output is expected to accept, popped as handshakes are observed.
module tb_floo_mcast_fork;

   localparam int NumOutputs = 5;
   localparam int CntWidth   = 4;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic                  valid_i;
   logic                  ready_o;
   logic [7:0]            data_i;
   logic [NumOutputs-1:0] select_i;
   logic [2:0]            rep_coeff_i;
   logic [NumOutputs-1:0] valid_o;
   logic [NumOutputs-1:0] ready_i;
   logic [7:0]            data_o;
   logic                  busy_o;
   logic                  empty_sel_o;
   logic [CntWidth-1:0]   fork_cnt_o;

   int checks = 0;
   int errors = 0;
   logic [CntWidth-1:0] expCnt = '0;
   logic [7:0] expQ [NumOutputs][$];

   floo_mcast_fork #(
      .NumOutputs (NumOutputs),
      .flit_t     (logic [7:0]),
      .CntWidth   (CntWidth)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .data_i      (data_i),
      .select_i    (select_i),
      .rep_coeff_i (rep_coeff_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .data_o      (data_o),
      .busy_o      (busy_o),
      .empty_sel_o (empty_sel_o),
      .fork_cnt_o  (fork_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Every observed handshake must match the oldest flit queued for that port.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < NumOutputs; i++) begin
            if (valid_o[i] && ready_i[i]) begin
               checks++;
               if (expQ[i].size() == 0) begin
                  errors++;
                  $display("[TB] FAIL unexpected_hs port %0d: got data %0h, required no handshake", i, data_o);
               end else begin
                  logic [7:0] exp;
                  exp = expQ[i].pop_front();
                  if (data_o !== exp) begin
                     errors++;
                     $display("[TB] FAIL hs_data port %0d: got %0h required %0h", i, data_o, exp);
                  end
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] d, input logic [NumOutputs-1:0] sel);
      valid_i     = 1'b1;
      data_i      = d;
      select_i    = sel;
      rep_coeff_i = 3'($countones(sel));
      for (int i = 0; i < NumOutputs; i++)
         if (sel[i]) expQ[i].push_back(d);
   endtask

   task automatic test_reset();
      rst_i = 1'b1; valid_i = 1'b0; data_i = '0; select_i = '0; rep_coeff_i = '0; ready_i = '0;
      step();
      step();
      @(negedge clk_i);
      checks++;
      if ({valid_o, ready_o, busy_o, empty_sel_o, fork_cnt_o} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_state: got valid_o=%b ready_o=%b busy_o=%b empty=%b cnt=%0d required all 0",
                  valid_o, ready_o, busy_o, empty_sel_o, fork_cnt_o);
      end
      step();
      rst_i = 1'b0;
   endtask

   task automatic test_queues_empty(input string name);
      for (int i = 0; i < NumOutputs; i++) begin
         checks++;
         if (expQ[i].size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_missing_hs port %0d: got %0d pending required 0", name, i, expQ[i].size());
            expQ[i].delete();
         end
      end
   endtask

   task automatic test_count(input string name);
      @(negedge clk_i);
      checks++;
      if (fork_cnt_o !== expCnt) begin
         errors++;
         $display("[TB] FAIL %s_cnt: got %0d required %0d", name, fork_cnt_o, expCnt);
      end
   endtask

`ifndef FLOO_MCAST_FORK_CUT_EN
   task automatic test_broadcast();
      applyStimulus(8'hA1, 5'b10110);
      ready_i = 5'b11111;
      @(negedge clk_i);
      checks++;
      if ({valid_o, ready_o, busy_o} !== {5'b10110, 1'b1, 1'b0}) begin
         errors++;
         $display("[TB] FAIL bcast_out: got valid_o=%b ready_o=%b busy_o=%b required 10110 1 0", valid_o, ready_o, busy_o);
      end
      step();
      valid_i = 1'b0; ready_i = '0;
      expCnt++;
      test_count("bcast");
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bcast_busy: got %b required 0", busy_o);
      end
      step();
      test_queues_empty("bcast");
   endtask

   task automatic test_partial();
      logic [NumOutputs-1:0] rdy [3];
      logic [NumOutputs-1:0] expV [3];
      logic expR [3];
      logic expB [3];
      rdy  = '{5'b00001, 5'b00100, 5'b00010};
      expV = '{5'b00111, 5'b00110, 5'b00010};
      expR = '{1'b0, 1'b0, 1'b1};
      expB = '{1'b0, 1'b1, 1'b1};
      applyStimulus(8'h5C, 5'b00111);
      for (int c = 0; c < 3; c++) begin
         ready_i = rdy[c];
         @(negedge clk_i);
         checks++;
         if ({valid_o, ready_o, busy_o} !== {expV[c], expR[c], expB[c]}) begin
            errors++;
            $display("[TB] FAIL partial_c%0d: got valid_o=%b ready_o=%b busy_o=%b required %b %b %b",
                     c, valid_o, ready_o, busy_o, expV[c], expR[c], expB[c]);
         end
         step();
      end
      valid_i = 1'b0; ready_i = '0;
      expCnt++;
      test_count("partial");
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL partial_idle_busy: got %b required 0", busy_o);
      end
      step();
      test_queues_empty("partial");
   endtask

   task automatic test_empty_sel();
      applyStimulus(8'hEE, 5'b00000);
      ready_i = 5'b11111;
      @(negedge clk_i);
      checks++;
      if ({valid_o, ready_o, empty_sel_o} !== {5'b00000, 1'b1, 1'b0}) begin
         errors++;
         $display("[TB] FAIL empty_drop: got valid_o=%b ready_o=%b empty=%b required 00000 1 0", valid_o, ready_o, empty_sel_o);
      end
      step();
      valid_i = 1'b0; ready_i = '0;
      @(negedge clk_i);
      checks++;
      if (empty_sel_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL empty_pulse: got %b required 1", empty_sel_o);
      end
      test_count("empty");
      step();
      @(negedge clk_i);
      checks++;
      if (empty_sel_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL empty_pulse_end: got %b required 0", empty_sel_o);
      end
      step();
   endtask

   task automatic test_back_to_back();
      applyStimulus(8'h11, 5'b00011);
      ready_i = 5'b11111;
      @(negedge clk_i);
      checks++;
      if ({valid_o, ready_o} !== {5'b00011, 1'b1}) begin
         errors++;
         $display("[TB] FAIL b2b_a: got valid_o=%b ready_o=%b required 00011 1", valid_o, ready_o);
      end
      step();
      applyStimulus(8'h22, 5'b11000);
      @(negedge clk_i);
      checks++;
      if ({valid_o, ready_o} !== {5'b11000, 1'b1}) begin
         errors++;
         $display("[TB] FAIL b2b_b: got valid_o=%b ready_o=%b required 11000 1", valid_o, ready_o);
      end
      step();
      valid_i = 1'b0; ready_i = '0;
      expCnt += 2;
      test_count("b2b");
      step();
      test_queues_empty("b2b");
   endtask

   task automatic test_reset_mid_fork();
      applyStimulus(8'h33, 5'b00111);
      ready_i = 5'b00101;
      @(negedge clk_i);
      checks++;
      if (ready_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rmf_ready: got %b required 0", ready_o);
      end
      step();
      ready_i = '0;
      @(negedge clk_i);
      checks++;
      if ({valid_o, busy_o} !== {5'b00010, 1'b1}) begin
         errors++;
         $display("[TB] FAIL rmf_pending: got valid_o=%b busy_o=%b required 00010 1", valid_o, busy_o);
      end
      rst_i = 1'b1;
      #1;
      checks++;
      if ({valid_o, ready_o, busy_o} !== '0) begin
         errors++;
         $display("[TB] FAIL rmf_in_reset: got valid_o=%b ready_o=%b busy_o=%b required 0 0 0", valid_o, ready_o, busy_o);
      end
      expQ[0].push_back(8'h33);
      expQ[2].push_back(8'h33);
      step();
      rst_i = 1'b0;
      ready_i = 5'b11111;
      @(negedge clk_i);
      checks++;
      if ({valid_o, ready_o} !== {5'b00111, 1'b1}) begin
         errors++;
         $display("[TB] FAIL rmf_reoffer: got valid_o=%b ready_o=%b required 00111 1", valid_o, ready_o);
      end
      step();
      valid_i = 1'b0; ready_i = '0;
      expCnt = '0 + 1'b1;
      test_count("rmf");
      step();
      test_queues_empty("rmf");
   endtask

   task automatic test_wrap();
      int n;
      n = 0;
      ready_i = 5'b00001;
      while (expCnt != 4'd15) begin
         applyStimulus(8'(n), 5'b00001);
         @(negedge clk_i);
         checks++;
         if (ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_ready_%0d: got %b required 1", n, ready_o);
         end
         step();
         expCnt++;
         n++;
      end
      valid_i = 1'b0;
      test_count("wrap_pre");
      step();
      applyStimulus(8'hF0, 5'b00001);
      step();
      valid_i = 1'b0; ready_i = '0;
      expCnt++;
      test_count("wrap_post");
      step();
      test_queues_empty("wrap");
   endtask
`else
   task automatic test_cut();
      applyStimulus(8'hC1, 5'b10110);
      ready_i = 5'b11111;
      @(negedge clk_i);
      checks++;
      if ({valid_o, ready_o} !== {5'b00000, 1'b1}) begin
         errors++;
         $display("[TB] FAIL cut_latency0: got valid_o=%b ready_o=%b required 00000 1", valid_o, ready_o);
      end
      step();
      valid_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (valid_o !== 5'b10110) begin
         errors++;
         $display("[TB] FAIL cut_latency1: got valid_o=%b required 10110", valid_o);
      end
      step();
      for (int k = 0; k < 8; k++) begin
         applyStimulus(8'(8'h40 + k), 5'b11111);
         @(negedge clk_i);
         checks++;
         if (ready_o !== 1'b1 || (k > 0 && valid_o !== 5'b11111)) begin
            errors++;
            $display("[TB] FAIL cut_tput_%0d: got ready_o=%b valid_o=%b required 1 11111", k, ready_o, valid_o);
         end
         step();
      end
      valid_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (valid_o !== 5'b11111) begin
         errors++;
         $display("[TB] FAIL cut_last: got valid_o=%b required 11111", valid_o);
      end
      step();
      ready_i = '0;
      expCnt += 9;
      test_count("cut");
      step();
      test_queues_empty("cut");
   endtask
`endif

   initial begin
      test_reset();
`ifndef FLOO_MCAST_FORK_CUT_EN
      test_broadcast();
      test_partial();
      test_empty_sel();
      test_back_to_back();
      test_reset_mid_fork();
      test_wrap();
`else
      test_cut();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/floo_mcast_fork.md
Name: floo_mcast_fork

Overview:
- Downstream of the route-computation stage in the chimney/router input path.
- Takes one flit plus the multicast destination select mask produced upstream and replicates it to every selected output port.
- Each output completes its valid/ready handshake independently; the input is released only once all selected outputs have accepted.
- Per-output completion tracking lets slow outputs stall without re-sending to outputs that already accepted.

Parameters:
- NumOutputs, 5, number of output ports, one bit per port in select.
- flit_t, logic, flit payload type.
- CntWidth, 16, width of the completed-multicast counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  input flit valid.
- ready_o  output  1  input flit accepted; all selected outputs done.
- data_i  input  flit_t  input flit.
- select_i  input  NumOutputs  destination mask from route computation.
- rep_coeff_i  input  $clog2(NumOutputs)+1  expected replication count (popcount of select_i).
- valid_o  output  NumOutputs  per-output valid.
- ready_i  input  NumOutputs  per-output ready.
- data_o  output  flit_t  flit, shared by all outputs.
- busy_o  output  1  fork partially complete (done mask non-zero).
- empty_sel_o  output  1  one-cycle pulse: flit with select_i==0 was dropped.
- fork_cnt_o  output  CntWidth  number of completed multicast flits, wraps.

Behaviour:
- Reset (async, rst_i=1) values: done_q='0, fork_cnt_q='0, empty_sel_o=0, valid_o='0, ready_o=0, busy_o=0.
- Reset mid-fork clears done_q. On release, the pending flit is re-offered to all selected outputs. Duplicates are possible and accepted.
- State is held in done_q[NumOutputs-1:0]:
  - IDLE: done_q==0.
  - FORKING: done_q!=0.
- valid_o[i] = valid_i & select_i[i] & ~done_q[i]. This is combinational; there is zero-cycle latency in the base configuration.
- hs[i] = valid_o[i] & ready_i[i].
- all_done = ((done_q | hs) & select_i) == select_i.
- ready_o = valid_i & all_done.
- Each clock edge:
  - If ready_o: done_q <= 0 (back to IDLE).
  - Otherwise: done_q <= done_q | hs (enter or stay in FORKING).
- Simultaneous acceptance by all selected outputs in one cycle: ready_o=1 the same cycle and done_q stays 0.
- Empty select (valid_i & select_i==0):
  - all_done=1, so ready_o=1 and the flit is dropped.
  - empty_sel_o pulses for one cycle, registered, visible the cycle after the drop.
  - fork_cnt_o is not incremented.
- fork_cnt_q increments by 1 on each ready_o with select_i!=0. It wraps from 2^CntWidth-1 to 0.
- busy_o = |done_q.
- data_o = data_i, unregistered in the base configuration.
- Input rule: data_i, select_i and rep_coeff_i must remain stable while valid_i & ~ready_o. valid_i must not drop before ready_o. Violations are flagged by assertion (simulation only).
- Assertion: valid_i implies popcount(select_i)==rep_coeff_i.
- Outputs that already accepted see valid_o[i]=0 until the next flit. They must not be re-offered.
- Extra 1s in ready_i for unselected ports are ignored.

Optional Feature:
- Macro: FLOO_MCAST_FORK_CUT_EN.
- Defined:
  - Input goes through a two-entry spill register (full throughput) holding data, select and rep_coeff.
  - Fork logic operates on the register output, so input-to-output latency is 1 cycle.
  - ready_o comes from the spill register and does not combinationally depend on ready_i.
  - Reset empties both entries.
  - Empty-select drop, counting and the pulse happen at register output.
- Not defined: the purely combinational path described above, with 0-cycle latency.

Test Plan:
- select_i=5'b10110, all ready_i=1 -> valid_o=5'b10110 same cycle, ready_o=1, done_q stays 0, fork_cnt_o 0->1.
- select_i=5'b00111; ready_i=5'b00001 at cycle 0, 5'b00100 at cycle 1, 5'b00010 at cycle 2:
  - valid_o = 00111, then 00110, then 00010.
  - ready_o=1 only at cycle 2, busy_o=1 at cycles 1-2.
  - Each port sees exactly one handshake.
- select_i=0, valid_i=1 -> ready_o=1 immediately, no valid_o, empty_sel_o=1 next cycle, fork_cnt_o unchanged.
- Back-to-back flits A (sel 00011), B (sel 11000), ready_i all 1 -> A completes cycle 0, B cycle 1, fork_cnt_o=2, no bubble.
- rst_i asserted with done_q=00101 on sel 00111 -> valid_o=0 during reset; after release valid_o=00111 again.
- Preload fork_cnt near wrap (CntWidth=4, 15 completions) then one more flit -> fork_cnt_o 15->0.
- With FLOO_MCAST_FORK_CUT_EN: a single flit appears on valid_o one cycle after input acceptance; 8 back-to-back flits with all ready_i=1 sustain 1 flit/cycle.
